// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int LEN_BYTES  = 4;
    localparam int CSUM_BYTES = 1;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running XOR
// of the bytes flagged by xor_en.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic        xor_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            // Shift right so the first byte of a word ends up in [7:0].
            shift_d = {byte_in, shift_q[31:8]};
            if (xor_en) begin
                csum_d = csum_q ^ byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
            csum_q  <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
        end
    end

    // The completed word is presented combinationally with its 4th byte.
    assign word_valid = byte_valid && (cnt_q == 2'd3);
    assign word       = {byte_in, shift_q[31:8]};
    assign csum       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: LEN / DATA / CSUM byte stream in, one word write per 4 data
// bytes out; holds the core in reset until the image checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        nwords_q, nwords_d;
    logic               in_ready_q, in_ready_d;
    logic               we_q, we_d;
    logic [31:0]        waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               accept;
    logic               asm_valid;
    logic               word_valid;
    logic [31:0]        word;
    logic [7:0]         csum;

    assign accept    = in_valid && in_ready_q;
    assign asm_valid = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (asm_valid),
        .xor_en     (state_q == ST_DATA),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nwords_d = nwords_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_LEN: begin
                if (word_valid) begin
                    nwords_d = word;
                    if (word > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = word;
                    waddr_d = BASE_ADDR + (32'(idx_q) << 2);
                    idx_d   = idx_q + 1'b1;
                    if (32'(idx_d) == nwords_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: ;
        endcase
        // Dropping ready together with the deciding byte guarantees no byte
        // beyond the checksum is ever consumed.
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN;
            idx_q      <= '0;
            nwords_q   <= 32'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= BASE_ADDR;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nwords_q   <= nwords_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign done     = (state_q == ST_DONE);
    assign err      = (state_q == ST_ERR);
    assign core_rst = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE 0 and BASE 0x1000),
// both DEPTH=16, selected by sel.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        sel;

    logic        rdy0, we0, crst0, done0, err0;
    logic        rdy1, we1, crst1, done1, err1;
    logic [31:0] wa0, wd0, wa1, wd1;

    logic        o_in_ready, o_we, o_core_rst, o_done, o_err;
    logic [31:0] o_waddr, o_wdata;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cyc;

    logic [31:0] img[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(.DEPTH(16), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_data(in_data),
        .in_ready(rdy0), .we(we0), .waddr(wa0), .wdata(wd0),
        .core_rst(crst0), .done(done0), .err(err0)
    );

    imem_loader #(.DEPTH(16), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_data(in_data),
        .in_ready(rdy1), .we(we1), .waddr(wa1), .wdata(wd1),
        .core_rst(crst1), .done(done1), .err(err1)
    );

    assign o_in_ready = sel ? rdy1  : rdy0;
    assign o_we       = sel ? we1   : we0;
    assign o_waddr    = sel ? wa1   : wa0;
    assign o_wdata    = sel ? wd1   : wd0;
    assign o_core_rst = sel ? crst1 : crst0;
    assign o_done     = sel ? done1 : done0;
    assign o_err      = sel ? err1  : err0;

    always @(negedge clk) begin
        if (o_we === 1'b1) begin
            wq_addr.push_back(o_waddr);
            wq_data.push_back(o_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        if (stall) begin
            for (int k = 0; k < 6 && $urandom_range(0, 1) == 1; k++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (o_in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", {31'd0, o_in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    endtask

    task automatic send_image(input bit stall);
        send_word(32'(img.size()), stall);
        foreach (img[i]) send_word(img[i], stall);
    endtask

    function automatic logic [7:0] img_xor();
        logic [7:0] x = 8'h00;
        foreach (img[i]) x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        return x;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, o_in_ready}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag, input logic [31:0] base);
        chk({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd0);
        chk({tag, "_we"},       {31'd0, o_we},       32'd0);
        chk({tag, "_waddr"},    o_waddr,             base);
        chk({tag, "_wdata"},    o_wdata,             32'd0);
        chk({tag, "_core_rst"}, {31'd0, o_core_rst}, 32'd1);
        chk({tag, "_done"},     {31'd0, o_done},     32'd0);
        chk({tag, "_err"},      {31'd0, o_err},      32'd0);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base);
        chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(img.size()));
        for (int i = 0; i < img.size() && i < wq_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], base + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wq_data[i], img[i]);
        end
    endtask

    // Sends image plus checksum and checks done timing, idle-after and writes.
    task automatic run_good(input string tag, input bit stall, input logic [7:0] cs,
                            input logic [31:0] base);
        send_image(stall);
        chk({tag, "_done_pre"}, {31'd0, o_done}, 32'd0);
        send_byte(cs, stall);
        done_cyc = cyc;
        chk({tag, "_done"},     {31'd0, o_done},     32'd1);
        chk({tag, "_core_rst"}, {31'd0, o_core_rst}, 32'd0);
        chk({tag, "_err"},      {31'd0, o_err},      32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk({tag, "_ready_after"}, {31'd0, o_in_ready}, 32'd0);
        chk({tag, "_done_held"},   {31'd0, o_done},     32'd1);
        in_valid = 1'b0;
        check_writes(tag, base);
        if (wq_cyc.size() > 0)
            chk({tag, "_we_before_done"}, {31'd0, wq_cyc[wq_cyc.size()-1] < done_cyc}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset", 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_rise", {31'd0, o_in_ready}, 32'd1);
        $display("step: reset state");

        img = '{32'h0062E233, 32'h00842383, 32'hFFC4A303};
        run_good("nominal", 1'b0, 8'h0C, 32'h0);
        $display("step: nominal load, writes=%0d", wq_addr.size());

        do_reset();
        run_good("stall", 1'b1, 8'h0C, 32'h0);
        $display("step: stalled load, writes=%0d", wq_addr.size());

        do_reset();
        img = '{32'h00000013};
        send_image(1'b0);
        send_byte(8'hFF, 1'b0);
        chk("badcs_err",      {31'd0, o_err},      32'd1);
        chk("badcs_core_rst", {31'd0, o_core_rst}, 32'd1);
        chk("badcs_done",     {31'd0, o_done},     32'd0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("badcs_ready", {31'd0, o_in_ready}, 32'd0);
        chk("badcs_err_held", {31'd0, o_err}, 32'd1);
        in_valid = 1'b0;
        check_writes("badcs", 32'h0);
        $display("step: bad checksum");

        do_reset();
        send_word(32'd17, 1'b0);
        chk("over_err",   {31'd0, o_err},      32'd1);
        chk("over_ready", {31'd0, o_in_ready}, 32'd0);
        @(negedge clk);
        chk("over_nwrites", 32'(wq_addr.size()), 32'd0);
        $display("step: N=DEPTH+1");

        do_reset();
        img.delete();
        send_word(32'd0, 1'b0);
        chk("zero_ready", {31'd0, o_in_ready}, 32'd1);
        chk("zero_err",   {31'd0, o_err},      32'd0);
        send_byte(8'h00, 1'b0);
        chk("zero_done", {31'd0, o_done}, 32'd1);
        @(negedge clk);
        chk("zero_nwrites", 32'(wq_addr.size()), 32'd0);
        $display("step: N=0");

        do_reset();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(32'hA500_0000 + 32'(i) * 32'h0001_0203);
        run_good("full", 1'b0, img_xor(), 32'h0);
        if (wq_addr.size() > 0) chk("full_last_addr", wq_addr[wq_addr.size()-1], 32'h0000_003C);
        $display("step: N=DEPTH, writes=%0d", wq_addr.size());

        do_reset();
        img = '{32'h0062E233, 32'h00842383, 32'hFFC4A303};
        send_word(32'd3, 1'b0);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        @(negedge clk);
        chk("mid_nwrites", 32'(wq_addr.size()), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst", 32'h0);
        do_reset();
        img = '{32'h11223344, 32'hAABBCCDD, 32'h01020304};
        run_good("reload", 1'b0, img_xor(), 32'h0);
        $display("step: reset mid-load and reload");

        sel = 1'b1;
        do_reset();
        img = '{32'hDEADBEEF, 32'h12345678};
        run_good("base", 1'b0, img_xor(), 32'h0000_1000);
        $display("step: BASE_ADDR=0x1000, writes=%0d", wq_addr.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
